adsr_env: RTL
=============

ADSR_ENV -- requirements
Module: adsr_env

Interface
REQ-001 The block SHALL have parameter DL, default 16, meaning signed sample width.
REQ-002 The block SHALL have parameter WL, default 8, meaning rate-prescaler word width.
REQ-003 The block SHALL have parameter SW, default 5, meaning shift-amount width; MAX_SH = DL-1, required to fit in SW bits.
REQ-004 The block SHALL have port CLK, input, 1, meaning the single clock, rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 The block SHALL have port EN, input, 1, meaning sample strobe: stepping and output update only on cycles with EN=1.
REQ-007 The block SHALL have port gate, input, 1, meaning note on (1) / note off (0).
REQ-008 The block SHALL have port data_in, input, signed DL, meaning the sample to attenuate.
REQ-009 The block SHALL have ports A_rate, D_rate and R_rate, each input, WL, meaning EN-cycles per step minus 1 for attack, decay and release.
REQ-010 The block SHALL have port S_level, input, SW, meaning sustain shift amount; values above MAX_SH are clamped to MAX_SH.
REQ-011 The block SHALL have port data_out, output, signed DL, meaning the registered attenuated sample.
REQ-012 The block SHALL have port total, output, SW, meaning the current shift amount.
REQ-013 The block SHALL have port state, output, 3, meaning IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
REQ-014 The block SHALL have port z_flg, output, 1, meaning a one-cycle pulse when attack reaches shift 0.
REQ-015 The block SHALL have port done, output, 1, meaning a one-cycle pulse on RELEASE->IDLE.
REQ-016 The block SHALL have port busy, output, 1, meaning state != IDLE (combinational from state).

Function
REQ-017 The block SHALL register gate every CLK into gate_q; rise = gate & ~gate_q, fall = ~gate & gate_q; gate edges SHALL act on any clock, independent of EN.
REQ-018 The prescaler SHALL be a WL-bit counter that advances only when EN=1 and state is ATTACK, DECAY or RELEASE; a step SHALL occur when the counter equals the active rate, after which the counter SHALL clear, so the step period is rate+1 EN cycles.
REQ-019 The prescaler SHALL clear on every state change.
REQ-020 IDLE: total=MAX_SH; on rise -> ATTACK.
REQ-021 ATTACK: each step SHALL decrement total by 1; on the step that makes total 0 -> DECAY and z_flg=1 for that cycle.
REQ-022 ATTACK: fall SHALL cause a transition to RELEASE with total held.
REQ-023 DECAY: if total == clamped S_level -> SUSTAIN on the next clock with no step; otherwise each step SHALL increment total by 1 and transition to SUSTAIN when it equals S_level; S_level=0 gives a zero-length decay.
REQ-024 SUSTAIN: total SHALL be held and track no S_level changes; fall -> RELEASE.
REQ-025 DECAY: fall SHALL cause a transition to RELEASE.
REQ-026 RELEASE: each step SHALL increment total by 1; on the step reaching MAX_SH -> IDLE and done=1 for that cycle.
REQ-027 RELEASE: rise SHALL retrigger ATTACK from the current total, with no reset to MAX_SH.
REQ-028 ATTACK, DECAY or SUSTAIN: a rise with no intervening fall SHALL NOT occur by construction; when rise and a step coincide, the gate transition SHALL win and the step SHALL be discarded.
REQ-029 total SHALL saturate within 0..MAX_SH with no wrap.
REQ-030 Data path: on EN=1, data_out SHALL be set to data_in >>> total (arithmetic) using the total value before that clock's update, giving 1 cycle latency.
REQ-031 Data path: on EN=1 in IDLE, data_out SHALL be set to 0.
REQ-032 Data path: on EN=0, data_out SHALL hold its value.
REQ-033 Rate and level inputs SHALL be sampled live each cycle, with no latching.

Reset
REQ-034 While rst_n=0, outputs SHALL be: state=IDLE, total=MAX_SH, data_out=0, z_flg=0, done=0, busy=0, with prescaler=0 and gate_q=0.
REQ-035 Reset asserted mid-envelope SHALL abort immediately with no done pulse; after release, gate held high SHALL produce a rise on the first clock and start ATTACK.

Verification
REQ-036 The bench SHALL apply DL=16, EN=1, A_rate=0, gate 0->1 and expect total 15->0 over 15 cycles, z_flg pulse on the cycle total hits 0, then DECAY.
REQ-037 The bench SHALL apply A_rate=3, D_rate=1, S_level=4, data_in=16'sh4000, gate held and expect an attack of 60 EN cycles, a decay of 8 EN cycles, then SUSTAIN with total=4 and data_out=16'sh0400.
REQ-038 The bench SHALL apply gate fall in SUSTAIN with R_rate=0 and expect RELEASE 4->15 in 11 cycles, a done pulse, IDLE, and data_out=0 thereafter.
REQ-039 The bench SHALL apply gate rise during RELEASE at total=9 and expect ATTACK resuming from 9, not 15.
REQ-040 The bench SHALL toggle EN 1-in-4 with A_rate=0 and expect the attack to take 60 clocks with data_out changing only on EN cycles.
REQ-041 The bench SHALL apply rst_n=0 mid-ATTACK and expect all outputs at reset values asynchronously, with no done pulse; data_in=-16'sd2 at total=15 SHALL give data_out=-1.

Source files
------------

// File: rtl/adsr_env.sv
// adsr_env: ADSR envelope that attenuates a signed sample stream by a right shift.
// The shift amount ("total") runs MAX_SH -> 0 (attack), 0 -> S_level (decay),
// holds (sustain), then climbs back to MAX_SH (release). Steps are paced by a
// prescaler that counts EN strobes.
//
// Ports
//   CLK      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   EN       : sample strobe; envelope stepping and data_out update only when high
//   gate     : note on (1) / note off (0); edges act on any clock
//   data_in  : signed sample to attenuate
//   A_rate   : attack  EN-cycles per step minus 1
//   D_rate   : decay   EN-cycles per step minus 1
//   R_rate   : release EN-cycles per step minus 1
//   S_level  : sustain shift amount, clamped to MAX_SH
//   data_out : registered data_in >>> total (0 while idle)
//   total    : current shift amount
//   state    : IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
//   z_flg    : one-cycle pulse when attack reaches shift 0
//   done     : one-cycle pulse on RELEASE -> IDLE
//   busy     : state != IDLE (combinational)
//
// MAX_SH = DL-1 must fit in SW bits.

module adsr_env #(
  parameter int unsigned DL = 16,
  parameter int unsigned WL = 8,
  parameter int unsigned SW = 5
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 EN,
  input  logic                 gate,
  input  logic signed [DL-1:0] data_in,
  input  logic        [WL-1:0] A_rate,
  input  logic        [WL-1:0] D_rate,
  input  logic        [WL-1:0] R_rate,
  input  logic        [SW-1:0] S_level,
  output logic signed [DL-1:0] data_out,
  output logic        [SW-1:0] total,
  output logic        [2:0]    state,
  output logic                 z_flg,
  output logic                 done,
  output logic                 busy
);

  localparam logic [SW-1:0] MAX_SH = SW'(DL - 1);
  localparam logic [SW-1:0] ONE    = SW'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  // Registered state
  state_t             state_q;
  logic [SW-1:0]      total_q;
  logic [WL-1:0]      cnt_q;
  logic               gate_q;
  logic signed [DL-1:0] dout_q;
  logic               z_q;
  logic               done_q;

  // Next-state / helper signals
  state_t             state_d;
  logic [SW-1:0]      total_d;
  logic [WL-1:0]      cnt_d;
  logic signed [DL-1:0] dout_d;
  logic               z_d;
  logic               done_d;
  logic               rise;
  logic               fall;
  logic               active;
  logic               step;
  logic [WL-1:0]      rate_sel;
  logic [SW-1:0]      s_clamp;

  // Gate edge detection, independent of EN
  assign rise = gate & ~gate_q;
  assign fall = ~gate & gate_q;

  assign s_clamp = (S_level > MAX_SH) ? MAX_SH : S_level;

  // Rate for the current stepping phase; prescaler idles in IDLE/SUSTAIN
  always_comb begin
    rate_sel = '0;
    active   = 1'b0;
    case (state_q)
      ST_ATTACK:  begin rate_sel = A_rate; active = 1'b1; end
      ST_DECAY:   begin rate_sel = D_rate; active = 1'b1; end
      ST_RELEASE: begin rate_sel = R_rate; active = 1'b1; end
      default:    begin rate_sel = '0;     active = 1'b0; end
    endcase
  end

  assign step = EN & active & (cnt_q == rate_sel);

  // Envelope next-state; gate edges take priority over a coincident step
  always_comb begin
    state_d = state_q;
    total_d = total_q;
    z_d     = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        total_d = MAX_SH;
        if (rise) state_d = ST_ATTACK;
      end
      ST_ATTACK: begin
        if (fall) begin
          state_d = ST_RELEASE;
        end else if (step) begin
          // Saturating decrement; a retrigger from 0 still completes the attack
          total_d = (total_q == '0) ? '0 : total_q - ONE;
          if (total_q <= ONE) begin
            state_d = ST_DECAY;
            z_d     = 1'b1;
          end
        end
      end
      ST_DECAY: begin
        if (fall) begin
          state_d = ST_RELEASE;
        end else if (total_q >= s_clamp) begin
          // Already at (or past, after a live S_level drop) the sustain level
          state_d = ST_SUSTAIN;
        end else if (step) begin
          total_d = total_q + ONE;
          if (total_d == s_clamp) state_d = ST_SUSTAIN;
        end
      end
      ST_SUSTAIN: begin
        if (fall) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (rise) begin
          state_d = ST_ATTACK;
        end else if (step) begin
          if (total_q >= MAX_SH - ONE) begin
            total_d = MAX_SH;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            total_d = total_q + ONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        total_d = MAX_SH;
      end
    endcase
  end

  // Prescaler: clears on any state change and after each step
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (EN && active) begin
      cnt_d = step ? '0 : cnt_q + WL'(1);
    end
  end

  // Data path uses the shift amount before this clock's update
  always_comb begin
    dout_d = dout_q;
    if (EN) begin
      if (state_q == ST_IDLE) dout_d = '0;
      else                    dout_d = data_in >>> total_q;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      total_q <= MAX_SH;
      cnt_q   <= '0;
      gate_q  <= 1'b0;
      dout_q  <= '0;
      z_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      cnt_q   <= cnt_d;
      gate_q  <= gate;
      dout_q  <= dout_d;
      z_q     <= z_d;
      done_q  <= done_d;
    end
  end

  assign data_out = dout_q;
  assign total    = total_q;
  assign state    = 3'(state_q);
  assign z_flg    = z_q;
  assign done     = done_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
